// File: rtl/light_pen_detect_pkg.sv
// -----------------------------------------------------------------------------
// light_pen_detect_pkg
// Shared definitions for the light-pen detector: FSM state encodings and the
// default timing parameters used by light_pen_detect.
// -----------------------------------------------------------------------------
package light_pen_detect_pkg;

    // Slot FSM states
    typedef enum logic [1:0] {
        LPD_IDLE   = 2'd0,
        LPD_SETTLE = 2'd1,
        LPD_SAMPLE = 2'd2,
        LPD_DONE   = 2'd3
    } lpd_state_t;

    // Cycles ignored after a scan advance (LED turn-on plus phototransistor delay)
    localparam int LPD_SETTLE_CYC  = 8;
    // Consecutive synchronised-high cycles that qualify a hit
    localparam int LPD_HIT_MIN     = 4;
    // Scan points per frame; a whole frame of misses drops pen presence
    localparam int LPD_FRAME_SLOTS = 64;
    // Width of the settle/hit counters
    localparam int LPD_CNT_W       = 8;

endpackage

// File: rtl/light_pen_detect_onehot8_enc.sv
// -----------------------------------------------------------------------------
// onehot8_enc
// Converts an 8-bit one-hot vector to a 3-bit binary index.
//   vec   : 8-bit input vector (expected one-hot)
//   idx   : binary index of the set bit (meaningless when valid = 0)
//   valid : high when exactly one bit of vec is set
// -----------------------------------------------------------------------------
module onehot8_enc (
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       valid
);

    // Each index bit is the OR of the vector bits whose position has that bit set
    always_comb begin
        idx[0] = vec[1] | vec[3] | vec[5] | vec[7];
        idx[1] = vec[2] | vec[3] | vec[6] | vec[7];
        idx[2] = vec[4] | vec[5] | vec[6] | vec[7];
        valid  = $onehot(vec);
    end

endmodule

// File: rtl/light_pen_detect.sv
// -----------------------------------------------------------------------------
// light_pen_detect
// Generates the light-pen write strobe for the LED matrix driver. The raw
// phototransistor signal is synchronised, ignored while the newly addressed LED
// and the sensor settle, then a run of HIT_MIN high samples qualifies a hit on
// the currently lit scan point. A qualified hit on a cell other than the last
// written one produces a single-cycle `we` while that point is still addressed.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous active-high reset
//   pen_in      : raw asynchronous phototransistor output (high = light seen)
//   scan_tick   : one-cycle pulse when led_row/led_col move to a new point
//   led_row     : one-hot active row
//   led_col     : one-hot active column
//   we          : one-cycle write strobe
//   hit_row     : binary row of the last written hit
//   hit_col     : binary column of the last written hit
//   pen_present : high while a hit qualified within the last FRAME_SLOTS points
//   scan_err    : sticky flag, a scan point was not one-hot at slot start
// -----------------------------------------------------------------------------
module light_pen_detect
    import light_pen_detect_pkg::*;
#(
    parameter int SETTLE_CYC  = LPD_SETTLE_CYC,
    parameter int HIT_MIN     = LPD_HIT_MIN,
    parameter int FRAME_SLOTS = LPD_FRAME_SLOTS,
    parameter int CNT_W       = LPD_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pen_in,
    input  logic       scan_tick,
    input  logic [7:0] led_row,
    input  logic [7:0] led_col,
    output logic       we,
    output logic [2:0] hit_row,
    output logic [2:0] hit_col,
    output logic       pen_present,
    output logic       scan_err
);

    localparam int               MISS_W      = $clog2(FRAME_SLOTS);
    localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(FRAME_SLOTS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] HIT_LAST    = CNT_W'(HIT_MIN - 1);

    logic              pen_meta_r;
    logic              pen_sync_r;
    lpd_state_t        state_r;
    logic [CNT_W-1:0]  settle_cnt_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [MISS_W-1:0] miss_cnt_r;
    logic [2:0]        slot_row_r;
    logic [2:0]        slot_col_r;
    logic              slot_hit_r;
    logic              dedup_valid_r;
    logic [2:0]        dedup_row_r;
    logic [2:0]        dedup_col_r;
    logic              we_r;
    logic [2:0]        hit_row_r;
    logic [2:0]        hit_col_r;
    logic              pen_present_r;
    logic              scan_err_r;

    logic [2:0]        row_idx_s;
    logic [2:0]        col_idx_s;
    logic              row_valid_s;
    logic              col_valid_s;
    logic              same_cell_s;

    onehot8_enc u_row_enc (
        .vec   (led_row),
        .idx   (row_idx_s),
        .valid (row_valid_s)
    );

    onehot8_enc u_col_enc (
        .vec   (led_col),
        .idx   (col_idx_s),
        .valid (col_valid_s)
    );

    assign same_cell_s = dedup_valid_r && (dedup_row_r == slot_row_r) && (dedup_col_r == slot_col_r);

    // Two-flop synchroniser for the asynchronous phototransistor signal
    always_ff @(posedge clk) begin
        if (rst) begin
            pen_meta_r <= 1'b0;
            pen_sync_r <= 1'b0;
        end else begin
            pen_meta_r <= pen_in;
            pen_sync_r <= pen_meta_r;
        end
    end

    // Slot FSM, miss tracking, dedup memory and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= LPD_IDLE;
            settle_cnt_r  <= {CNT_W{1'b0}};
            hit_cnt_r     <= {CNT_W{1'b0}};
            miss_cnt_r    <= {MISS_W{1'b0}};
            slot_row_r    <= 3'd0;
            slot_col_r    <= 3'd0;
            slot_hit_r    <= 1'b0;
            dedup_valid_r <= 1'b0;
            dedup_row_r   <= 3'd0;
            dedup_col_r   <= 3'd0;
            we_r          <= 1'b0;
            hit_row_r     <= 3'd0;
            hit_col_r     <= 3'd0;
            pen_present_r <= 1'b0;
            scan_err_r    <= 1'b0;
        end else begin
            we_r <= 1'b0;
            if (scan_tick) begin
                // A tick always wins: the outgoing slot is abandoned, so a pending
                // write can never land on the newly addressed cell.
                if ((state_r != LPD_IDLE) && !slot_hit_r) begin
                    // Saturating miss count; the FRAME_SLOTS-th miss drops presence
                    if (miss_cnt_r == MISS_LAST) begin
                        pen_present_r <= 1'b0;
                        dedup_valid_r <= 1'b0;
                    end else begin
                        miss_cnt_r <= miss_cnt_r + MISS_W'(1);
                    end
                end
                slot_row_r   <= row_idx_s;
                slot_col_r   <= col_idx_s;
                settle_cnt_r <= {CNT_W{1'b0}};
                hit_cnt_r    <= {CNT_W{1'b0}};
                slot_hit_r   <= 1'b0;
                if (row_valid_s && col_valid_s) begin
                    state_r <= LPD_SETTLE;
                end else begin
                    scan_err_r <= 1'b1;
                    state_r    <= LPD_DONE;
                end
            end else begin
                case (state_r)
                    LPD_SETTLE: begin
                        if (settle_cnt_r == SETTLE_LAST) begin
                            state_r <= LPD_SAMPLE;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + CNT_W'(1);
                        end
                    end
                    LPD_SAMPLE: begin
                        if (pen_sync_r) begin
                            if (hit_cnt_r == HIT_LAST) begin
                                // Run complete. A repeat of the last written cell still
                                // proves the pen is present, so it also resets the miss
                                // count; otherwise a held-still pen would be re-written
                                // every frame.
                                slot_hit_r <= 1'b1;
                                miss_cnt_r <= {MISS_W{1'b0}};
                                state_r    <= LPD_DONE;
                                if (!same_cell_s) begin
                                    we_r          <= 1'b1;
                                    hit_row_r     <= slot_row_r;
                                    hit_col_r     <= slot_col_r;
                                    dedup_row_r   <= slot_row_r;
                                    dedup_col_r   <= slot_col_r;
                                    dedup_valid_r <= 1'b1;
                                    pen_present_r <= 1'b1;
                                end
                            end else begin
                                hit_cnt_r <= hit_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            hit_cnt_r <= {CNT_W{1'b0}};
                        end
                    end
                    LPD_IDLE, LPD_DONE: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= LPD_IDLE;
                    end
                endcase
            end
        end
    end

    assign we          = we_r;
    assign hit_row     = hit_row_r;
    assign hit_col     = hit_col_r;
    assign pen_present = pen_present_r;
    assign scan_err    = scan_err_r;

endmodule

// File: tb/tb_light_pen_detect.sv
// -----------------------------------------------------------------------------
// tb_light_pen_detect
// Self-checking bench for light_pen_detect: directed scenarios with literal
// expectations plus randomized slots, all outputs compared every cycle against
// a slot-level behavioural model.
// -----------------------------------------------------------------------------
module tb_light_pen_detect;

    localparam int SETTLE = 8;
    localparam int HITN   = 4;
    localparam int FRAME  = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pen_in = 1'b0;
    logic       scan_tick = 1'b0;
    logic [7:0] led_row = 8'h00;
    logic [7:0] led_col = 8'h00;
    logic       we;
    logic [2:0] hit_row;
    logic [2:0] hit_col;
    logic       pen_present;
    logic       scan_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    light_pen_detect dut (
        .clk         (clk),
        .rst         (rst),
        .pen_in      (pen_in),
        .scan_tick   (scan_tick),
        .led_row     (led_row),
        .led_col     (led_col),
        .we          (we),
        .hit_row     (hit_row),
        .hit_col     (hit_col),
        .pen_present (pen_present),
        .scan_err    (scan_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model (slot level) ----------------
    int   cyc = 0;
    int   last_rst = 0;
    bit   pin [0:65535];
    bit   m_we, m_pp, m_err;
    int   m_hr, m_hc;
    bit   slot_exists, slot_hit, slot_ok, dd_valid;
    int   t0, s_r, s_c, dd_r, dd_c, misses;

    function automatic bit is_onehot(input logic [7:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic int index_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Synchronised pen value seen in cycle c: raw input two cycles earlier,
    // zero while the synchroniser is still flushing after reset.
    function automatic bit pen_s_at(input int c);
        if (c - 2 <= last_rst) return 1'b0;
        return pin[c - 2];
    endfunction

    task automatic model_step();
        bit all_high;
        if (cyc < 65536) pin[cyc] = pen_in;
        if (rst) begin
            last_rst = cyc;
            m_we = 0; m_pp = 0; m_err = 0; m_hr = 0; m_hc = 0;
            slot_exists = 0; slot_hit = 0; dd_valid = 0; misses = 0;
        end else begin
            m_we = 0;
            if (scan_tick) begin
                if (slot_exists && !slot_hit) begin
                    misses++;
                    if (misses >= FRAME) begin
                        misses = FRAME;
                        m_pp = 0;
                        dd_valid = 0;
                    end
                end
                slot_exists = 1; slot_hit = 0; t0 = cyc;
                slot_ok = is_onehot(led_row) && is_onehot(led_col);
                if (!slot_ok) m_err = 1;
                s_r = index_of(led_row);
                s_c = index_of(led_col);
            end else if (slot_exists && slot_ok && !slot_hit && cyc >= t0 + SETTLE + HITN) begin
                all_high = 1;
                for (int j = 0; j < HITN; j++) if (!pen_s_at(cyc - j)) all_high = 0;
                if (all_high) begin
                    slot_hit = 1;
                    misses = 0;
                    if (!(dd_valid && dd_r == s_r && dd_c == s_c)) begin
                        m_we = 1; m_hr = s_r; m_hc = s_c;
                        dd_r = s_r; dd_c = s_c; dd_valid = 1; m_pp = 1;
                    end
                end
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    // Compare all outputs against the model on every cycle
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            cmp("model_we", int'(we), int'(m_we));
            cmp("model_hit_row", int'(hit_row), m_hr);
            cmp("model_hit_col", int'(hit_col), m_hc);
            cmp("model_pen_present", int'(pen_present), int'(m_pp));
            cmp("model_scan_err", int'(scan_err), int'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Runs one slot of len cycles (tick cycle is k=0); pen_in in cycle k is pat[k].
    // Returns how many we pulses were seen and the first cycle one was seen.
    task automatic run_slot(input logic [7:0] r, input logic [7:0] c, input int len,
                            input logic [63:0] pat, output int n, output int first);
        n = 0;
        first = -1;
        pen_in = pat[0];
        scan_tick = 1'b1;
        led_row = r;
        led_col = c;
        @(negedge clk);
        scan_tick = 1'b0;
        for (int k = 1; k < len; k++) begin
            if (we === 1'b1) begin
                n++;
                if (first < 0) first = k;
            end
            pen_in = pat[k];
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [63:0] gen_pat();
        logic [63:0] p;
        logic cur;
        cur = 1'($urandom_range(0, 1));
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 4) == 0) cur = ~cur;
            p[i] = cur;
        end
        return p;
    endfunction

    localparam logic [63:0] ONES = {64{1'b1}};
    localparam logic [63:0] ZERO = {64{1'b0}};

    initial begin
        int n, first;
        logic [63:0] pat;
        logic [7:0] r, c;

        // Reset
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("reset_we", int'(we), 0);
        cmp("reset_hit_row", int'(hit_row), 0);
        cmp("reset_hit_col", int'(hit_col), 0);
        cmp("reset_pen_present", int'(pen_present), 0);
        cmp("reset_scan_err", int'(scan_err), 0);

        // First hit: fires once on cycle 13 after the tick
        run_slot(8'h04, 8'h10, 20, ONES, n, first);
        cmp("first_hit_count", n, 1);
        cmp("first_hit_latency", first, 13);
        cmp("first_hit_row", int'(hit_row), 2);
        cmp("first_hit_col", int'(hit_col), 4);
        cmp("first_hit_present", int'(pen_present), 1);

        // Same cell again: suppressed
        run_slot(8'h04, 8'h10, 20, ONES, n, first);
        cmp("dedup_count", n, 0);

        // Neighbouring cell fires
        run_slot(8'h04, 8'h20, 20, ONES, n, first);
        cmp("new_cell_count", n, 1);
        cmp("new_cell_col", int'(hit_col), 5);

        // pen 3 high, 1 low, 4 high inside SAMPLE: fires after the 4-run
        pat = ZERO;
        pat[9:7] = 3'b111;
        pat[14:11] = 4'b1111;
        run_slot(8'h02, 8'h02, 25, pat, n, first);
        cmp("broken_run_count", n, 1);
        cmp("broken_run_latency", first, 17);

        // A HIT_MIN-1 pulse never fires
        pat = ZERO;
        pat[9:7] = 3'b111;
        run_slot(8'h08, 8'h08, 25, pat, n, first);
        cmp("short_pulse_count", n, 0);

        // Tick one cycle before the fire cycle aborts; next slot fires normally
        run_slot(8'h10, 8'h10, 12, ONES, n, first);
        cmp("abort_count", n, 0);
        run_slot(8'h10, 8'h10, 20, ONES, n, first);
        cmp("after_abort_count", n, 1);
        cmp("after_abort_latency", first, 13);

        // Missed frame: 64 empty slots after the hit slot drop presence
        for (int i = 1; i <= 65; i++) begin
            run_slot(8'h10, 8'h10, 3, ZERO, n, first);
            if (i == 64) cmp("present_before_frame_end", int'(pen_present), 1);
            if (i == 65) cmp("present_after_missed_frame", int'(pen_present), 0);
        end
        run_slot(8'h10, 8'h10, 20, ONES, n, first);
        cmp("refire_after_frame_count", n, 1);

        // Malformed scan points set a sticky error and never fire
        run_slot(8'h00, 8'h10, 20, ONES, n, first);
        cmp("zero_row_count", n, 0);
        cmp("zero_row_err", int'(scan_err), 1);
        run_slot(8'h03, 8'h10, 20, ONES, n, first);
        cmp("two_hot_row_count", n, 0);
        run_slot(8'h04, 8'h04, 20, ONES, n, first);
        cmp("good_after_err_count", n, 1);
        cmp("err_sticky", int'(scan_err), 1);
        do_reset();
        cmp("err_cleared_by_rst", int'(scan_err), 0);

        // Randomized slots over a small set of cells so dedup and misses recur
        for (int s = 0; s < 300; s++) begin
            r = 8'h01 << $urandom_range(0, 1);
            c = 8'h01 << $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) r = 8'($urandom_range(0, 255));
            pat = gen_pat();
            if ($urandom_range(0, 3) == 0) pat = ONES;
            if ($urandom_range(0, 40) == 0) do_reset();
            run_slot(r, c, $urandom_range(2, 32), pat, n, first);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
